// File: rtl/hog_pkg.sv
// hog_pkg
// Shared definitions for the HOG orientation path: the Q3.16 tangent
// format produced by tan_encode, its saturation code, the encoder FSM
// state type, and the tangent thresholds used by the bin decoder.
// There are no ports. Encoder and decoder import this package so that
// they use the same format and thresholds.
package hog_pkg;

   localparam int TAN_W    = 19;
   localparam int TAN_FRAC = 16;

   localparam logic [TAN_W-1:0] TAN_SAT = 19'h7FFFF;

   // These are floor(tan(angle) * 2^16) for 20, 40, 60 and 80 degrees.
   localparam logic [TAN_W-1:0] TAN20 = 19'd23853;
   localparam logic [TAN_W-1:0] TAN40 = 19'd54991;
   localparam logic [TAN_W-1:0] TAN60 = 19'd113511;
   localparam logic [TAN_W-1:0] TAN80 = 19'd371673;

   // The DIV state runs one edge per quotient bit.
   // The last step happens at counter value 18.
   localparam logic [4:0] DIV_LAST = 5'd18;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      DONE = 2'd2
   } tan_state_e;

endpackage

// File: rtl/tan_encode.sv
// tan_encode
// This block converts a gradient magnitude pair into the unsigned Q3.16
// ratio |Gy|/|Gx|. The result saturates at 19'h7FFFF. The block uses a
// bit-serial restoring divider that produces one quotient bit per clock.
// Three cases finish on the accepting edge:
//   - zero / zero
//   - x / zero
//   - a ratio of 8 or more
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   in_valid/in_ready   input handshake (in_ready is high only in IDLE)
//   gx_mag, gy_mag      unsigned |Gx|, |Gy| (MAG_W bits)
//   sgn_in              {sign Gy, sign Gx}, latched with the pair
//   out_valid/out_ready output handshake (out_valid is high only in DONE)
//   tan                 Q3.16 ratio, truncated
//   sgn_out             latched sgn_in
module tan_encode
   import hog_pkg::*;
#(
   parameter int MAG_W = 8
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [MAG_W-1:0] gx_mag,
   input  logic [MAG_W-1:0] gy_mag,
   input  logic [1:0]       sgn_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [TAN_W-1:0] tan,
   output logic [1:0]       sgn_out
);

   tan_state_e       state;
   tan_state_e       state_nxt;
   logic [4:0]       cnt;
   logic [MAG_W:0]   rem;
   logic [MAG_W-1:0] gx_q;
   logic [TAN_W-1:0] quo;
   logic [1:0]       sgn_q;

   logic             special;
   logic [TAN_W-1:0] special_tan;
   logic [MAG_W+1:0] rem_sh;
   logic [MAG_W+1:0] diff;
   logic             q_bit;
   logic [MAG_W:0]   rem_nxt;

   // A ratio of 8 or more does not fit in three integer bits, so it
   // saturates. When gx is zero, this comparison is always true.
   // That routes both zero-divisor cases through the fast path.
   assign special     = ({3'b000, gy_mag} >= {gx_mag, 3'b000});
   assign special_tan = ((gx_mag == '0) && (gy_mag == '0)) ? '0 : TAN_SAT;

   // Restoring division step.
   // The quotient register also acts as the dividend shifter: its MSB
   // feeds the remainder, and the new quotient bit enters at the LSB.
   // After 19 steps the register holds only the quotient.
   // A negative trial difference shows up as the top bit being set.
   assign rem_sh  = {rem, quo[TAN_W-1]};
   assign diff    = rem_sh - {2'b00, gx_q};
   assign q_bit   = ~diff[MAG_W+1];
   assign rem_nxt = q_bit ? diff[MAG_W:0] : rem_sh[MAG_W:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_nxt = special ? DONE : DIV;
            end
         end
         DIV: begin
            if (cnt == DIV_LAST) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // When a division starts, the remainder is seeded with gy >> 3.
   // This value is already below gx. Those leading steps would only
   // produce zero quotient bits, so they are skipped. The three low
   // gy bits and 16 zero bits of fraction are then shifted in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         rem   <= '0;
         gx_q  <= '0;
         quo   <= '0;
         sgn_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sgn_q <= sgn_in;
                  gx_q  <= gx_mag;
                  cnt   <= '0;
                  if (special) begin
                     rem <= '0;
                     quo <= special_tan;
                  end else begin
                     rem <= {4'b0000, gy_mag[MAG_W-1:3]};
                     quo <= {gy_mag[2:0], {TAN_FRAC{1'b0}}};
                  end
               end
            end
            DIV: begin
               rem <= rem_nxt;
               quo <= {quo[TAN_W-2:0], q_bit};
               cnt <= cnt + 5'd1;
            end
            default: begin
            end
         endcase
      end
   end

   assign tan     = quo;
   assign sgn_out = sgn_q;

endmodule

// File: tb/tb_tan_encode.sv
// tb_tan_encode
// Self-checking bench for tan_encode (MAG_W = 8). It runs three kinds of
// stimulus:
//   - a table of directed vectors
//   - hand-written reset-abort and hold sequences
//   - random pairs checked against an arithmetic reference model
module tb_tan_encode;
   import hog_pkg::*;

   localparam int MAG_W = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [MAG_W-1:0] gx_mag = '0;
   logic [MAG_W-1:0] gy_mag = '0;
   logic [1:0]       sgn_in = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [18:0]      tan;
   logic [1:0]       sgn_out;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0]  gx;
      logic [7:0]  gy;
      logic [1:0]  sgn;
      logic [18:0] tan;
      int          lat;
      int          hold;
   } vec_t;

   vec_t vecs[10];

   tan_encode #(.MAG_W(MAG_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .gx_mag    (gx_mag),
      .gy_mag    (gy_mag),
      .sgn_in    (sgn_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .tan       (tan),
      .sgn_out   (sgn_out)
   );

   always #5 clk = ~clk;

   // Reference result: the exact ratio with 16 fraction bits, truncated
   // and then clamped to the saturation code. Division by zero gives
   // zero for 0/0 and saturates otherwise.
   function automatic logic [18:0] refTan(input int gx, input int gy);
      longint q;
      if (gx == 0) return (gy == 0) ? 19'd0 : 19'h7FFFF;
      q = (longint'(gy) * 65536) / gx;
      if (q > 64'h7FFFF) return 19'h7FFFF;
      return q[18:0];
   endfunction

   // Edges between the accepting edge and out_valid going high.
   // The fast-path cases are already DONE after the accepting edge.
   // A real division adds 19 more edges.
   function automatic int refLat(input int gx, input int gy);
      if (gx == 0 || gy >= 8 * gx) return 0;
      return 19;
   endfunction

   task automatic checkOutput(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Runs one complete transaction from the IDLE state:
   //   1. Offer the pair for one edge.
   //   2. Drive garbage on the inputs while the block is busy.
   //   3. Wait for out_valid.
   //   4. Keep out_ready low for 'hold' cycles.
   //   5. Complete the output transfer.
   task automatic applyStimulus(input logic [7:0] gx, input logic [7:0] gy,
                                input logic [1:0] sgn, input int hold,
                                input logic [18:0] expTan, input int expLat);
      int lat;
      logic busyReady;
      gx_mag    = gx;
      gy_mag    = gy;
      sgn_in    = sgn;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      gx_mag    = 8'($urandom);
      gy_mag    = 8'($urandom);
      sgn_in    = 2'($urandom);
      lat       = 0;
      busyReady = 1'b0;
      while (!out_valid && lat < 40) begin
         if (in_ready) busyReady = 1'b1;
         @(posedge clk);
         #1;
         lat++;
      end
      in_valid = 1'b0;
      checkOutput("out_valid seen", out_valid, 1);
      checkOutput("latency", lat, expLat);
      checkOutput("in_ready low while busy", busyReady, 0);
      checkOutput("tan", tan, expTan);
      checkOutput("sgn_out", sgn_out, sgn);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         checkOutput("hold tan", tan, expTan);
         checkOutput("hold sgn_out", sgn_out, sgn);
         checkOutput("hold out_valid", out_valid, 1);
         checkOutput("hold in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkOutput("in_ready after transfer", in_ready, 1);
      checkOutput("out_valid after transfer", out_valid, 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic sawValid;
      int gx;
      int gy;

      vecs[0] = '{8'd100, 8'd36,  2'b10, 19'h05C28, 19, 0};
      vecs[1] = '{8'd50,  8'd50,  2'b01, 19'h10000, 19, 5};
      vecs[2] = '{8'd10,  8'd79,  2'b11, 19'h7E666, 19, 0};
      vecs[3] = '{8'd10,  8'd80,  2'b00, 19'h7FFFF, 0,  0};
      vecs[4] = '{8'd0,   8'd5,   2'b10, 19'h7FFFF, 0,  0};
      vecs[5] = '{8'd0,   8'd0,   2'b01, 19'h00000, 0,  2};
      vecs[6] = '{8'd255, 8'd1,   2'b11, 19'h00101, 19, 0};
      vecs[7] = '{8'd1,   8'd7,   2'b10, 19'h70000, 19, 1};
      vecs[8] = '{8'd1,   8'd8,   2'b01, 19'h7FFFF, 0,  0};
      vecs[9] = '{8'd255, 8'd255, 2'b11, 19'h10000, 19, 0};

      // Check the output values while reset is held.
      in_valid = 1'b1;
      gx_mag   = 8'd3;
      gy_mag   = 8'd1;
      #12;
      checkOutput("reset in_ready", in_ready, 1);
      checkOutput("reset out_valid", out_valid, 0);
      checkOutput("reset tan", tan, 0);
      checkOutput("reset sgn_out", sgn_out, 0);
      in_valid = 1'b0;

      // Release reset. The first vector must be accepted on the next edge.
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].gx, vecs[i].gy, vecs[i].sgn, vecs[i].hold,
                       vecs[i].tan, vecs[i].lat);
      end

      // Assert reset in the middle of a division, at counter value 10.
      gx_mag   = 8'd100;
      gy_mag   = 8'd36;
      sgn_in   = 2'b11;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      checkOutput("mid-DIV out_valid", out_valid, 0);
      rst_n = 1'b0;
      #1;
      checkOutput("abort in_ready", in_ready, 1);
      checkOutput("abort out_valid", out_valid, 0);
      checkOutput("abort tan", tan, 0);
      checkOutput("abort sgn_out", sgn_out, 0);
      @(negedge clk);
      rst_n    = 1'b1;
      sawValid = 1'b0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (out_valid) sawValid = 1'b1;
      end
      checkOutput("no result after abort", sawValid, 0);
      applyStimulus(8'd1, 8'd3, 2'b10, 0, 19'h30000, 19);

      // Random pairs, with extra weight on zero divisors and on the
      // boundary at a ratio of 8.
      for (int i = 0; i < 60; i++) begin
         gx = int'($urandom_range(0, 255));
         gy = int'($urandom_range(0, 255));
         if (i % 8 == 0) gx = 0;
         if (i % 10 == 3) begin
            gx = int'($urandom_range(1, 31));
            gy = 8 * gx - int'($urandom_range(0, 1));
         end
         applyStimulus(8'(gx), 8'(gy), 2'($urandom), int'($urandom_range(0, 2)),
                       refTan(gx, gy), refLat(gx, gy));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tan_encode.md
TAN_ENCODE -- requirements
Module: tan_encode

Interface
REQ-001 The block SHALL have one parameter, MAG_W, default 8, giving the width of the unsigned gradient magnitudes.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: a gradient pair is offered.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept a pair.
REQ-006 The block SHALL have port gx_mag, input, MAG_W bits: |Gx|.
REQ-007 The block SHALL have port gy_mag, input, MAG_W bits: |Gy|.
REQ-008 The block SHALL have port sgn_in, input, 2 bits: {sign Gy, sign Gx}, carried through unchanged.
REQ-009 The block SHALL have port out_valid, output, 1 bit: a result is presented.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream bin decoder accepts the result.
REQ-011 The block SHALL have port tan, output, 19 bits: unsigned Q3.16 ratio |Gy|/|Gx|, in the format the tangent-to-bin decoder consumes.
REQ-012 The block SHALL have port sgn_out, output, 2 bits: the sgn_in value captured with the accepted pair.

Function
REQ-013 Transfers SHALL use valid/ready: an input is accepted on a rising edge with in_valid && in_ready; an output is consumed on a rising edge with out_valid && out_ready.
REQ-014 The FSM SHALL have exactly three states: IDLE, DIV and DONE.
REQ-015 in_ready SHALL equal (state == IDLE) and out_valid SHALL equal (state == DONE); there is no input/output overlap.
REQ-016 On an accept in IDLE, the block SHALL latch gx_mag, gy_mag and sgn_in.
REQ-017 The exact result SHALL be tan = min(floor(gy*2^16/gx), 19'h7FFFF).
REQ-018 If gx == 0 and gy == 0 (special case), tan SHALL be 0 and the FSM SHALL go IDLE->DONE on the accepting edge (out_valid in the next cycle).
REQ-019 If gx == 0 and gy != 0 (special case), tan SHALL be 19'h7FFFF and the FSM SHALL go IDLE->DONE on the accepting edge.
REQ-020 If gy >= 8*gx with gx != 0 (saturation, special case), tan SHALL be 19'h7FFFF and the FSM SHALL go IDLE->DONE on the accepting edge.
REQ-021 Otherwise the FSM SHALL enter DIV with a 5-bit iteration counter at 0.
REQ-022 In DIV the block SHALL perform one restoring-division step per edge, producing quotient bits MSB first: 3 integer bits, then 16 fraction bits.
REQ-023 The partial remainder SHALL be MAG_W+1 bits wide, so that no step overflows.
REQ-024 After the 19th DIV edge (counter == 18) the FSM SHALL go to DONE, so out_valid rises 19 edges after the accepting edge.
REQ-025 The quotient SHALL be truncated, never rounded.
REQ-026 In DONE, tan and sgn_out SHALL hold stable while out_ready = 0.
REQ-027 DONE SHALL go to IDLE on the edge where out_ready = 1; the next accept is possible one edge later.
REQ-028 in_valid, gx_mag and gy_mag SHALL be ignored outside IDLE.

Reset
REQ-029 While rst_n = 0, the block SHALL force state = IDLE, counter = 0, tan = 0, sgn_out = 0, out_valid = 0 and in_ready = 1, asynchronously.
REQ-030 Reset asserted mid-DIV or mid-DONE SHALL abort the operation and discard it; no result SHALL be emitted after release.
REQ-031 The first accept after reset release SHALL be possible on the first rising edge with in_valid = 1.

Structure
REQ-032 A shared hog_pkg SHALL hold TAN_W = 19, TAN_FRAC = 16, TAN_SAT = 19'h7FFFF, the FSM state enum and the tan20/tan40/tan60/tan80 bin thresholds, so that encoder and decoder share one definition.
REQ-033 The block SHALL be a single module with no sub-module; the division step is inline logic.

Verification
REQ-034 The bench SHALL cover: gx=100, gy=36 -> tan=19'h05C28, out_valid 19 edges after accept, sgn_out = sgn_in.
REQ-035 The bench SHALL cover: gx=50, gy=50 -> tan=19'h10000.
REQ-036 The bench SHALL cover: gx=10, gy=79 -> tan=19'h7E666 via DIV; then gx=10, gy=80 -> 19'h7FFFF with out_valid one cycle after accept.
REQ-037 The bench SHALL cover: gx=0, gy=5 -> 19'h7FFFF; gx=0, gy=0 -> 0; both with one-cycle latency.
REQ-038 The bench SHALL cover: out_ready held low for 5 cycles in DONE -> tan, sgn_out and out_valid stable, in_ready = 0, then one transfer and in_ready = 1 on the next edge.
REQ-039 The bench SHALL cover: rst_n pulsed low at DIV counter = 10 -> outputs at reset values immediately, and no out_valid until a new accept.
